// File: rtl/spi_pkg.sv
// Shared SPI master types: FSM state encoding, SPI mode constants, select-width helper.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LEAD,
        SHIFT,
        TRAIL
    } spiState_e;

    // {cpol, cpha}
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    function automatic int selWidth(input int numSlaves);
        return (numSlaves > 1) ? $clog2(numSlaves) : 1;
    endfunction

endpackage

// File: rtl/spi_clkgen.sv
// SCLK timing base: counts CLK_DIV clk cycles per tick and marks leading/trailing SCLK edges.
module spi_clkgen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic shiftEn,
    output logic tick,
    output logic leadEdge,
    output logic trailEdge
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic             phase;  // 0: the next toggle moves SCLK away from its idle level

    assign tick      = run && (cnt == CNT_LAST);
    assign leadEdge  = tick && shiftEn && !phase;
    assign trailEdge = tick && shiftEn && phase;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (!run) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
            if (!shiftEn) begin
                phase <= 1'b0;
            end else if (tick) begin
                phase <= ~phase;
            end
        end
    end

endmodule

// File: rtl/spi_master_gen.sv
// Parameterised SPI master: one frame per accepted start, selectable mode, bit order and slave.
module spi_master_gen
    import spi_pkg::*;
#(
    parameter int  DATA_WIDTH = 8,
    parameter int  NUM_SLAVES = 3,
    parameter int  CLK_DIV    = 2,
    localparam int SEL_WIDTH  = selWidth(NUM_SLAVES)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [SEL_WIDTH-1:0]  slaveSelect,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic                  lsbFirst,
    input  logic [DATA_WIDTH-1:0] masterDataToSend,
    output logic [DATA_WIDTH-1:0] masterDataReceived,
    output logic                  busy,
    output logic                  done,
    output logic                  selError,
    output logic                  SCLK,
    output logic [NUM_SLAVES-1:0] CS,
    output logic                  MOSI,
    input  logic                  MISO,
    output spiState_e             fsmState
);

    localparam int HC_W = $clog2(2 * DATA_WIDTH);
    localparam logic [HC_W-1:0] LAST_HALF = HC_W'(2 * DATA_WIDTH - 1);

    spiState_e             state;
    logic [NUM_SLAVES-1:0] csN;
    logic                  sclkR, mosiR, busyR, doneR, selErrR;
    logic                  cphaR, lsbR;
    logic [DATA_WIDTH-1:0] txShift, rxShift, rxData;
    logic [HC_W-1:0]       hcnt;
    logic                  tick, leadEdge, trailEdge;
    logic                  selOk, accept, sampleEdge, shiftEdge, nextBit;

    // Handshake: start is a request sampled only while busy is low; it is accepted when the
    // selected slave exists, otherwise selError pulses. busy stays high until the cycle after done.
    assign selOk  = int'(slaveSelect) < NUM_SLAVES;
    assign accept = start && !busyR && selOk;

    assign sampleEdge = cphaR ? trailEdge : leadEdge;
    assign shiftEdge  = cphaR ? leadEdge  : trailEdge;
    assign nextBit    = lsbR ? txShift[0] : txShift[DATA_WIDTH-1];

    spi_clkgen #(
        .CLK_DIV (CLK_DIV)
    ) u_clkgen (
        .clk       (clk),
        .reset     (reset),
        .run       (state != IDLE),
        .shiftEn   (state == SHIFT),
        .tick      (tick),
        .leadEdge  (leadEdge),
        .trailEdge (trailEdge)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            csN     <= '1;
            sclkR   <= 1'b0;
            mosiR   <= 1'b0;
            busyR   <= 1'b0;
            doneR   <= 1'b0;
            selErrR <= 1'b0;
            cphaR   <= 1'b0;
            lsbR    <= 1'b0;
            txShift <= '0;
            rxShift <= '0;
            rxData  <= '0;
            hcnt    <= '0;
        end else begin
            doneR   <= 1'b0;
            selErrR <= 1'b0;
            case (state)
                IDLE: begin
                    sclkR <= cpol;
                    mosiR <= 1'b0;
                    busyR <= 1'b0;
                    if (accept) begin
                        state   <= LEAD;
                        busyR   <= 1'b1;
                        cphaR   <= cpha;
                        lsbR    <= lsbFirst;
                        hcnt    <= '0;
                        rxShift <= '0;
                        for (int i = 0; i < NUM_SLAVES; i++) begin
                            csN[i] <= (i != int'(slaveSelect));
                        end
                        // cpha=0 presents the first bit as soon as CS falls
                        if (!cpha) begin
                            mosiR   <= lsbFirst ? masterDataToSend[0] : masterDataToSend[DATA_WIDTH-1];
                            txShift <= lsbFirst ? (masterDataToSend >> 1) : (masterDataToSend << 1);
                        end else begin
                            txShift <= masterDataToSend;
                        end
                    end else if (start && !busyR) begin
                        selErrR <= 1'b1;
                    end
                end
                LEAD: begin
                    if (tick) state <= SHIFT;
                end
                SHIFT: begin
                    if (tick) begin
                        sclkR <= ~sclkR;
                        hcnt  <= hcnt + 1'b1;
                        if (hcnt == LAST_HALF) state <= TRAIL;
                        if (sampleEdge) begin
                            rxShift <= lsbR ? {MISO, rxShift[DATA_WIDTH-1:1]}
                                            : {rxShift[DATA_WIDTH-2:0], MISO};
                        end
                        if (shiftEdge) begin
                            mosiR   <= nextBit;
                            txShift <= lsbR ? (txShift >> 1) : (txShift << 1);
                        end
                    end
                end
                TRAIL: begin
                    if (tick) begin
                        state  <= IDLE;
                        csN    <= '1;
                        mosiR  <= 1'b0;
                        doneR  <= 1'b1;
                        rxData <= rxShift;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign masterDataReceived = rxData;
    assign busy     = busyR;
    assign done     = doneR;
    assign selError = selErrR;
    assign SCLK     = sclkR;
    assign CS       = csN;
    assign MOSI     = mosiR;
    assign fsmState = state;

endmodule

// File: tb/tb_spi_master_gen.sv
// Bench for spi_master_gen: an 8-bit/CLK_DIV=2 and a 16-bit/CLK_DIV=1 instance share one SPI slave model.
module tb_spi_master_gen;
    import spi_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start8 = 1'b0, start16 = 1'b0;
    logic [1:0]  slaveSelect = 2'd0;
    logic        cpol = 1'b0, cpha = 1'b0, lsbFirst = 1'b0;
    logic [31:0] txWord = 32'h0;
    logic        miso = 1'b0;
    logic        useWide = 1'b0;

    logic [7:0]  rx8;
    logic        busy8, done8, selErr8, sclk8, mosi8;
    logic [2:0]  cs8;
    spiState_e   state8;
    logic [15:0] rx16;
    logic        busy16, done16, selErr16, sclk16, mosi16;
    logic [2:0]  cs16;
    spiState_e   state16;

    logic        sclkA, mosiA, doneA, selErrA;
    logic [2:0]  csA;
    assign sclkA   = useWide ? sclk16 : sclk8;
    assign mosiA   = useWide ? mosi16 : mosi8;
    assign doneA   = useWide ? done16 : done8;
    assign selErrA = useWide ? selErr16 : selErr8;
    assign csA     = useWide ? cs16 : cs8;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] exp_q[$];
    logic [31:0] seen_q[$];

    // slave model and monitor state
    logic [31:0] slvRet = 0, slvSeen = 0;
    logic        slvCpol = 0, slvCpha = 0, slvLsb = 0, slvFirstMosi = 0;
    int          slvDw = 8, slvBitIdx = 0, slvRxIdx = 0;
    logic        prevCsLow = 0, prevSclk = 0;
    logic [2:0]  csMask = 0;
    int sclkToggles = 0, csLowCnt = 0, lastCsLowCnt = 0, csHighRun = 0, lastGap = 0;
    int doneCnt = 0, selErrCnt = 0, csMultiErr = 0, mosiIdleErr = 0, doneCsErr = 0;

    always #5 clk = ~clk;

    spi_master_gen #(.DATA_WIDTH(8), .NUM_SLAVES(3), .CLK_DIV(2)) u_dut8 (
        .clk(clk), .reset(reset), .start(start8), .slaveSelect(slaveSelect),
        .cpol(cpol), .cpha(cpha), .lsbFirst(lsbFirst), .masterDataToSend(txWord[7:0]),
        .masterDataReceived(rx8), .busy(busy8), .done(done8), .selError(selErr8),
        .SCLK(sclk8), .CS(cs8), .MOSI(mosi8), .MISO(miso), .fsmState(state8)
    );

    spi_master_gen #(.DATA_WIDTH(16), .NUM_SLAVES(3), .CLK_DIV(1)) u_dut16 (
        .clk(clk), .reset(reset), .start(start16), .slaveSelect(slaveSelect),
        .cpol(cpol), .cpha(cpha), .lsbFirst(lsbFirst), .masterDataToSend(txWord[15:0]),
        .masterDataReceived(rx16), .busy(busy16), .done(done16), .selError(selErr16),
        .SCLK(sclk16), .CS(cs16), .MOSI(mosi16), .MISO(miso), .fsmState(state16)
    );

    function automatic logic slvBit(input int i);
        if (i >= slvDw) return 1'b0;
        return slvLsb ? slvRet[i] : slvRet[slvDw-1-i];
    endfunction

    always @(negedge clk) begin : monitor
        if (csA != 3'b111) begin
            if (!prevCsLow) begin
                slvSeen = 0; slvBitIdx = 0; slvRxIdx = 0; sclkToggles = 0; csLowCnt = 0;
                csMask = ~csA; lastGap = csHighRun;
                if (!slvCpha) miso = slvBit(0);
            end else if (sclkA != prevSclk) begin
                sclkToggles++;
                if ((sclkA != slvCpol) == !slvCpha) begin
                    if (slvRxIdx == 0) slvFirstMosi = mosiA;
                    if (slvRxIdx < slvDw) begin
                        if (slvLsb) slvSeen[slvRxIdx] = mosiA;
                        else slvSeen[slvDw-1-slvRxIdx] = mosiA;
                    end
                    slvRxIdx++;
                end else if (slvCpha) begin
                    miso = slvBit(slvBitIdx); slvBitIdx++;
                end else begin
                    slvBitIdx++; miso = slvBit(slvBitIdx);
                end
            end
            csLowCnt++;
            csHighRun = 0;
            if (csA != 3'b110 && csA != 3'b101 && csA != 3'b011) csMultiErr++;
        end else begin
            if (prevCsLow) lastCsLowCnt = csLowCnt;
            csHighRun++;
            if (mosiA !== 1'b0) mosiIdleErr++;
        end
        if (doneA === 1'b1) begin
            doneCnt++;
            if (csA !== 3'b111) doneCsErr++;
        end
        if (selErrA === 1'b1) selErrCnt++;
        prevCsLow = (csA != 3'b111);
        prevSclk  = sclkA;
    end

    task automatic drive_frame(input bit wide, input logic [1:0] sel, input bit pol, input bit pha,
                               input bit lsb, input logic [31:0] tx, input logic [31:0] ret,
                               input int settle);
        @(negedge clk);
        useWide = wide; cpol = pol; cpha = pha; lsbFirst = lsb; slaveSelect = sel; txWord = tx;
        slvCpol = pol; slvCpha = pha; slvLsb = lsb; slvRet = ret; slvDw = wide ? 16 : 8;
        repeat (settle) @(negedge clk);
        exp_q.push_back(ret);
        seen_q.push_back(tx);
        if (wide) start16 = 1'b1; else start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0; start16 = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (doneA === 1'b1) begin ok = 1'b1; break; end
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; cpol = 1'b1;
        repeat (3) @(negedge clk);
        vectors++; if (cs8 !== 3'b111) begin miscompares++; $display("FAIL reset_cs: got %b expected 111", cs8); end
        vectors++; if (sclk8 !== 1'b0) begin miscompares++; $display("FAIL reset_sclk: got %b expected 0", sclk8); end
        vectors++; if ({mosi8, busy8, done8, selErr8} !== 4'b0) begin miscompares++; $display("FAIL reset_flags: got %b expected 0000", {mosi8, busy8, done8, selErr8}); end
        vectors++; if (rx8 !== 8'h0) begin miscompares++; $display("FAIL reset_rx: got %h expected 00", rx8); end
        vectors++; if (state8 !== IDLE) begin miscompares++; $display("FAIL reset_state: got %0d expected IDLE", state8); end
        vectors++; if ({cs16, rx16} !== {3'b111, 16'h0}) begin miscompares++; $display("FAIL reset_wide: got %b/%h expected 111/0000", cs16, rx16); end
        reset = 1'b1;
        @(posedge clk); #1;
        vectors++; if (sclk8 !== 1'b1) begin miscompares++; $display("FAIL sclk_first_edge: got %b expected 1", sclk8); end
        cpol = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        bit ok; int d0; logic [31:0] e;
        d0 = doneCnt;
        drive_frame(0, 2'd1, 0, 0, 0, 32'h53, 32'h22, 2);
        wait_done(ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL basic_done: got timeout expected done"); end
        e = exp_q.pop_front();
        vectors++; if ({24'h0, rx8} !== e) begin miscompares++; $display("FAIL basic_rx: got %h expected %h", rx8, e); end
        e = seen_q.pop_front();
        vectors++; if (slvSeen !== e) begin miscompares++; $display("FAIL basic_slave_rx: got %h expected %h", slvSeen, e); end
        vectors++; if (lastCsLowCnt !== 36) begin miscompares++; $display("FAIL basic_cs_low: got %0d expected 36", lastCsLowCnt); end
        vectors++; if (csMask !== 3'b010) begin miscompares++; $display("FAIL basic_cs_sel: got %b expected 010", csMask); end
        vectors++; if (busy8 !== 1'b1) begin miscompares++; $display("FAIL basic_busy_done_cycle: got %b expected 1", busy8); end
        @(negedge clk); #1;
        vectors++; if (busy8 !== 1'b0) begin miscompares++; $display("FAIL basic_busy_fall: got %b expected 0", busy8); end
        repeat (3) @(negedge clk); #1;
        vectors++; if (doneCnt - d0 !== 1) begin miscompares++; $display("FAIL basic_done_count: got %0d expected 1", doneCnt - d0); end
    endtask

    task automatic test_modes();
        bit ok; bit pol, pha; logic [31:0] e;
        for (int m = 0; m < 4; m++) begin
            pol = m[1]; pha = m[0];
            @(negedge clk); cpol = pol; cpha = pha;
            repeat (2) @(negedge clk);
            vectors++; if (sclk8 !== pol) begin miscompares++; $display("FAIL mode%0d_sclk_before: got %b expected %b", m, sclk8, pol); end
            drive_frame(0, 2'd0, pol, pha, 0, 32'hAC, 32'hC9, 1);
            wait_done(ok);
            vectors++; if (!ok) begin miscompares++; $display("FAIL mode%0d_done: got timeout expected done", m); end
            e = exp_q.pop_front();
            vectors++; if ({24'h0, rx8} !== e) begin miscompares++; $display("FAIL mode%0d_rx: got %h expected %h", m, rx8, e); end
            e = seen_q.pop_front();
            vectors++; if (slvSeen !== e) begin miscompares++; $display("FAIL mode%0d_slave_rx: got %h expected %h", m, slvSeen, e); end
            vectors++; if (sclkToggles !== 16) begin miscompares++; $display("FAIL mode%0d_toggles: got %0d expected 16", m, sclkToggles); end
            repeat (2) @(negedge clk);
            vectors++; if (sclk8 !== pol) begin miscompares++; $display("FAIL mode%0d_sclk_after: got %b expected %b", m, sclk8, pol); end
        end
    endtask

    task automatic test_lsb_first();
        bit ok; logic [31:0] e;
        drive_frame(0, 2'd2, 0, 0, 1, 32'h01, 32'h80, 2);
        wait_done(ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL lsb_done: got timeout expected done"); end
        vectors++; if (slvFirstMosi !== 1'b1) begin miscompares++; $display("FAIL lsb_first_bit: got %b expected 1", slvFirstMosi); end
        e = exp_q.pop_front();
        vectors++; if ({24'h0, rx8} !== e) begin miscompares++; $display("FAIL lsb_rx: got %h expected %h", rx8, e); end
        e = seen_q.pop_front();
        vectors++; if (slvSeen !== e) begin miscompares++; $display("FAIL lsb_slave_rx: got %h expected %h", slvSeen, e); end
        lsbFirst = 1'b0;
    endtask

    task automatic test_sel_error();
        bit ok; int d0, s0; logic [31:0] e;
        d0 = doneCnt; s0 = selErrCnt;
        @(negedge clk); useWide = 1'b0; slaveSelect = 2'd3; start8 = 1'b1;
        @(negedge clk); start8 = 1'b0;
        vectors++; if (selErr8 !== 1'b1) begin miscompares++; $display("FAIL selerr_pulse: got %b expected 1", selErr8); end
        vectors++; if ({cs8, busy8} !== 4'b1110) begin miscompares++; $display("FAIL selerr_idle: got %b expected 1110", {cs8, busy8}); end
        @(negedge clk);
        vectors++; if (selErr8 !== 1'b0) begin miscompares++; $display("FAIL selerr_width: got %b expected 0", selErr8); end
        drive_frame(0, 2'd2, 0, 0, 0, 32'h96, 32'h3B, 1);
        repeat (6) @(negedge clk);
        vectors++; if (busy8 !== 1'b1) begin miscompares++; $display("FAIL busy_mid_frame: got %b expected 1", busy8); end
        slaveSelect = 2'd0; txWord = 32'hFF; start8 = 1'b1;
        @(negedge clk); slaveSelect = 2'd3;
        @(negedge clk); start8 = 1'b0;
        wait_done(ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL busy_done: got timeout expected done"); end
        e = exp_q.pop_front();
        vectors++; if ({24'h0, rx8} !== e) begin miscompares++; $display("FAIL busy_rx: got %h expected %h", rx8, e); end
        e = seen_q.pop_front();
        vectors++; if (slvSeen !== e) begin miscompares++; $display("FAIL busy_slave_rx: got %h expected %h", slvSeen, e); end
        vectors++; if (csMask !== 3'b100) begin miscompares++; $display("FAIL busy_cs_sel: got %b expected 100", csMask); end
        repeat (4) @(negedge clk); #1;
        vectors++; if (doneCnt - d0 !== 1) begin miscompares++; $display("FAIL busy_done_count: got %0d expected 1", doneCnt - d0); end
        vectors++; if (selErrCnt - s0 !== 1) begin miscompares++; $display("FAIL selerr_count: got %0d expected 1", selErrCnt - s0); end
    endtask

    task automatic test_reset_mid_frame();
        bit ok; bit hit; int d0; logic [31:0] e;
        d0 = doneCnt; hit = 1'b0;
        drive_frame(0, 2'd1, 0, 0, 0, 32'h55, 32'h99, 1);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); #1;
            if (sclkToggles == 5) begin hit = 1'b1; break; end
        end
        vectors++; if (!hit) begin miscompares++; $display("FAIL abort_edge5: got %0d toggles expected 5", sclkToggles); end
        reset = 1'b0; #1;
        void'(exp_q.pop_back());
        void'(seen_q.pop_back());
        vectors++; if ({cs8, busy8, done8, sclk8, mosi8} !== 7'b1110000) begin miscompares++; $display("FAIL abort_outputs: got %b expected 1110000", {cs8, busy8, done8, sclk8, mosi8}); end
        vectors++; if (state8 !== IDLE) begin miscompares++; $display("FAIL abort_state: got %0d expected IDLE", state8); end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (40) @(negedge clk); #1;
        vectors++; if (doneCnt !== d0) begin miscompares++; $display("FAIL abort_no_done: got %0d expected %0d", doneCnt, d0); end
        vectors++; if (rx8 !== 8'h0) begin miscompares++; $display("FAIL abort_rx: got %h expected 00", rx8); end
        drive_frame(0, 2'd0, 0, 0, 0, 32'h3C, 32'hA5, 1);
        wait_done(ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL after_abort_done: got timeout expected done"); end
        e = exp_q.pop_front();
        vectors++; if ({24'h0, rx8} !== e) begin miscompares++; $display("FAIL after_abort_rx: got %h expected %h", rx8, e); end
        e = seen_q.pop_front();
        vectors++; if (slvSeen !== e) begin miscompares++; $display("FAIL after_abort_slave_rx: got %h expected %h", slvSeen, e); end
    endtask

    task automatic test_wide();
        bit ok; logic [31:0] e;
        logic [15:0] txTab [2] = '{16'hBEEF, 16'hA5C3};
        logic [15:0] retTab[2] = '{16'h1234, 16'h0F1E};
        bit          lsbTab[2] = '{1'b0, 1'b1};
        bit          phaTab[2] = '{1'b0, 1'b1};
        for (int k = 0; k < 2; k++) begin
            drive_frame(1, 2'd2, 0, phaTab[k], lsbTab[k], {16'h0, txTab[k]}, {16'h0, retTab[k]}, 2);
            wait_done(ok);
            vectors++; if (!ok) begin miscompares++; $display("FAIL wide%0d_done: got timeout expected done", k); end
            e = exp_q.pop_front();
            vectors++; if ({16'h0, rx16} !== e) begin miscompares++; $display("FAIL wide%0d_rx: got %h expected %h", k, rx16, e); end
            e = seen_q.pop_front();
            vectors++; if (slvSeen !== e) begin miscompares++; $display("FAIL wide%0d_slave_rx: got %h expected %h", k, slvSeen, e); end
            vectors++; if (lastCsLowCnt !== 34) begin miscompares++; $display("FAIL wide%0d_cs_low: got %0d expected 34", k, lastCsLowCnt); end
        end
        @(negedge clk); useWide = 1'b0; lsbFirst = 1'b0; cpha = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        bit ok; bit pol, pha, lsb; logic [31:0] e, tx, ret;
        for (int n = 0; n < 5; n++) begin
            pol = 1'($urandom_range(0, 1)); pha = 1'($urandom_range(0, 1)); lsb = 1'($urandom_range(0, 1));
            tx  = 32'($urandom_range(0, 255)); ret = 32'($urandom_range(0, 255));
            drive_frame(0, 2'($urandom_range(0, 2)), pol, pha, lsb, tx, ret, (n == 0) ? 2 : 0);
            wait_done(ok);
            vectors++; if (!ok) begin miscompares++; $display("FAIL b2b%0d_done: got timeout expected done", n); end
            e = exp_q.pop_front();
            vectors++; if ({24'h0, rx8} !== e) begin miscompares++; $display("FAIL b2b%0d_rx: got %h expected %h", n, rx8, e); end
            e = seen_q.pop_front();
            vectors++; if (slvSeen !== e) begin miscompares++; $display("FAIL b2b%0d_slave_rx: got %h expected %h", n, slvSeen, e); end
            if (n > 0) begin
                vectors++; if (lastGap < 1) begin miscompares++; $display("FAIL b2b%0d_cs_gap: got %0d expected >=1", n, lastGap); end
            end
        end
    endtask

    task automatic test_invariants();
        vectors++; if (csMultiErr !== 0) begin miscompares++; $display("FAIL cs_onehot: got %0d bad cycles expected 0", csMultiErr); end
        vectors++; if (mosiIdleErr !== 0) begin miscompares++; $display("FAIL mosi_idle: got %0d bad cycles expected 0", mosiIdleErr); end
        vectors++; if (doneCsErr !== 0) begin miscompares++; $display("FAIL done_cs_high: got %0d bad cycles expected 0", doneCsErr); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_modes();
        test_lsb_first();
        test_sel_error();
        test_reset_mid_frame();
        test_wide();
        test_back_to_back();
        test_invariants();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
